// File: rtl/playbus_pkg.sv
// Shared types for the PlayBus sequencer: controller state codes, function codes, FSM states.
package playbus_pkg;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_START = 2'd1,
        PB_WRITE = 2'd2,
        PB_END   = 2'd3
    } pb_st_t;

    typedef logic [2:0] pb_func_t;

    localparam pb_func_t F_ROM     = 3'd0;
    localparam pb_func_t F_RAM     = 3'd1;
    localparam pb_func_t F_SW      = 3'd2;
    localparam pb_func_t F_SW2RAM  = 3'd3;
    localparam pb_func_t F_ROM2RAM = 3'd4;
    localparam pb_func_t F_SW2LED  = 3'd5;
    localparam pb_func_t F_ROM2LED = 3'd6;
    localparam pb_func_t F_RAM2LED = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DWELL   = 3'd1,
        S_ISSUE   = 3'd2,
        S_RELEASE = 3'd3,
        S_NEXT    = 3'd4
    } seq_t;

    // Functions from F_SW2RAM upward need the GO handshake.
    function automatic logic is_dynamic(input pb_func_t f);
        return f >= F_SW2RAM;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for an asynchronous push-button, plus a one-cycle rising-edge pulse.
module button_sync (
    input  logic CK2HZ,
    input  logic n_CLR,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb sync_d = {sync_q[1:0], d};

    always_ff @(posedge CK2HZ or negedge n_CLR) begin
        if (!n_CLR) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q    = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/playbus_seq.sv
// PlayBus sequencer: on START runs one latched function over ADDR_FIRST..ADDR_LAST (wrapping 15->0).
// Build macro PLAYBUS_SEQ_SINGLESTEP_EN adds a STEP button that gates every address advance.
module playbus_seq
    import playbus_pkg::*;
#(
    parameter int ADDR_FIRST = 0,
    parameter int ADDR_LAST  = 15,
    parameter int DWELL      = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic       CK2HZ,
    input  logic       n_CLR,
    input  logic       START,
    input  logic       ABORT,
`ifdef PLAYBUS_SEQ_SINGLESTEP_EN
    input  logic       STEP,
`endif
    input  logic [2:0] MODE,
    input  logic [1:0] St,
    output logic [3:0] ADD,
    output logic [2:0] FUNC,
    output logic       GO,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [3:0] A_FIRST   = 4'(ADDR_FIRST);
    localparam logic [3:0] A_LAST    = 4'(ADDR_LAST);
    localparam logic [3:0] DWELL_END = 4'(DWELL - 1);
    localparam logic [3:0] TMO_END   = 4'(TIMEOUT - 1);

    logic start_rise, abort_lvl, step_ok;
    logic start_lvl_unused, abort_rise_unused;

    button_sync u_start (.CK2HZ(CK2HZ), .n_CLR(n_CLR), .d(START), .q(start_lvl_unused), .rise(start_rise));
    button_sync u_abort (.CK2HZ(CK2HZ), .n_CLR(n_CLR), .d(ABORT), .q(abort_lvl), .rise(abort_rise_unused));

`ifdef PLAYBUS_SEQ_SINGLESTEP_EN
    logic step_lvl_unused;
    button_sync u_step (.CK2HZ(CK2HZ), .n_CLR(n_CLR), .d(STEP), .q(step_lvl_unused), .rise(step_ok));
`else
    assign step_ok = 1'b1;
`endif

    seq_t       state_q, state_d;
    pb_func_t   func_q, func_d;
    pb_st_t     st_e;
    logic [3:0] add_q, add_d, cnt_q, cnt_d;
    logic       go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d, stop_q, stop_d;

    assign st_e = pb_st_t'(St);

    always_comb begin
        state_d = state_q;
        add_d   = add_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        go_d    = go_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                go_d = 1'b0;
                if (start_rise) begin
                    func_d = MODE;
                    add_d  = A_FIRST;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    stop_d = 1'b0;
                    cnt_d  = '0;
                    if (is_dynamic(MODE)) begin
                        state_d = S_ISSUE;
                        go_d    = (st_e == PB_IDLE);
                    end else begin
                        state_d = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort_lvl) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == DWELL_END) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ISSUE: begin
                // A timeout ends the run like an abort, but only after the controller is released.
                if (go_q && st_e == PB_END) begin
                    go_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == TMO_END) begin
                    err_d   = 1'b1;
                    stop_d  = 1'b1;
                    go_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (abort_lvl) begin
                    stop_d  = 1'b1;
                    go_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (!go_q && st_e == PB_IDLE) go_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (abort_lvl) stop_d = 1'b1;
                if (st_e == PB_IDLE) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else if (cnt_q == TMO_END) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_NEXT: begin
                cnt_d = '0;
                if (abort_lvl || stop_q) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (add_q == A_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (step_ok) begin
                    add_d = add_q + 4'd1;
                    if (is_dynamic(func_q)) begin
                        state_d = S_ISSUE;
                        go_d    = (st_e == PB_IDLE);
                    end else begin
                        state_d = S_DWELL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK2HZ or negedge n_CLR) begin
        if (!n_CLR) begin
            state_q <= S_IDLE;
            add_q   <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
        end
    end

    assign ADD  = add_q;
    assign FUNC = func_q;
    assign GO   = go_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_playbus_seq.sv
// Bench for playbus_seq: two instances (2..4 and wrapping 14..1) driven by a controller model.
module tb_playbus_seq;

    localparam int P_FIRST [2] = '{2, 14};
    localparam int P_LAST  [2] = '{4, 1};
    localparam int P_DWELL [2] = '{4, 2};
    localparam int P_TMO   [2] = '{8, 8};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]      start = '0, abort = '0, stuck = '0, pre_busy = '0;
    logic [1:0][2:0] mode  = '0;
    logic [1:0][1:0] st;
    wire  [1:0][3:0] add;
    wire  [1:0][2:0] func;
    wire  [1:0]      go, busy, done, err;
    int dly [2] = '{0, 0};
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    playbus_seq #(.ADDR_FIRST(2), .ADDR_LAST(4), .DWELL(4), .TIMEOUT(8)) u_a (
        .CK2HZ(clk), .n_CLR(rst_n), .START(start[0]), .ABORT(abort[0]), .MODE(mode[0]), .St(st[0]),
        .ADD(add[0]), .FUNC(func[0]), .GO(go[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]));

    playbus_seq #(.ADDR_FIRST(14), .ADDR_LAST(1), .DWELL(2), .TIMEOUT(8)) u_b (
        .CK2HZ(clk), .n_CLR(rst_n), .START(start[1]), .ABORT(abort[1]), .MODE(mode[1]), .St(st[1]),
        .ADD(add[1]), .FUNC(func[1]), .GO(go[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]));

    // Controller model: idle -> start_source -> do_write (random stretch) -> end_dynamic until GO drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stuck[k]) st[k] <= 2'd0;
                else if (pre_busy[k]) st[k] <= 2'd3;
                else case (st[k])
                    2'd0: if (go[k]) st[k] <= 2'd1;
                    2'd1: begin st[k] <= 2'd2; dly[k] <= $urandom_range(0, 2); end
                    2'd2: if (dly[k] == 0) st[k] <= 2'd3; else dly[k] <= dly[k] - 1;
                    default: if (!go[k]) st[k] <= 2'd0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mism(input int x[$], input int y[$], input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (i >= x.size() || i >= y.size() || x[i] != y[i]) m++;
        return m;
    endfunction

    task automatic do_run(input int k, input logic [2:0] m, input int abort_idx,
                          input bit stk, input bit mid_start, input bit pre);
        int exp_q[$], got_q[$], seen_q[$];
        int a, n_exp, busy_cyc, done_cnt, go_len, bad, idle_busy;
        bit started, ended, dyn, go_prev, exp_done;
        logic [1:0] st_prev;
        logic [3:0] add_prev;
        dyn = (m >= 3'd3);
        a = P_FIRST[k];
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(a);
            if (a == P_LAST[k]) break;
            a = (a + 1) % 16;
        end
        n_exp    = exp_q.size();
        exp_done = !stk;
        if (stk) n_exp = 1;
        else if (dyn && abort_idx >= 0 && abort_idx < n_exp) begin
            n_exp    = abort_idx + 1;
            exp_done = 1'b0;
        end
        {busy_cyc, done_cnt, go_len, bad, idle_busy} = '0;
        {started, ended} = '0;
        stuck[k] = stk; pre_busy[k] = pre; mode[k] = m;
        repeat (2) @(negedge clk);
        start[k] = 1'b1;
        go_prev = go[k]; st_prev = st[k]; add_prev = add[k];
        for (int c = 0; c < 400 && !ended; c++) begin
            @(negedge clk);
            if (c == 3) start[k] = 1'b0;
            if (!started) begin
                if (busy[k]) begin
                    started  = 1'b1;
                    busy_cyc = 1;
                    pre_busy[k] = 1'b0;
                    chk("start_err_clear", err[k], 0);
                    chk("start_func", func[k], m);
                    chk("start_add", add[k], P_FIRST[k]);
                    seen_q.push_back(int'(add[k]));
                end
            end else begin
                busy_cyc += int'(busy[k]);
                if (add[k] != add_prev) begin
                    seen_q.push_back(int'(add[k]));
                    if (go_prev || st_prev != 2'd0) bad++;
                end
                if (!busy[k]) ended = 1'b1;
            end
            if (started) begin
                if (go[k] && !go_prev) begin
                    got_q.push_back(int'(add[k]));
                    if (st_prev != 2'd0) bad++;
                    if (abort_idx >= 0 && got_q.size() == abort_idx + 1) abort[k] = 1'b1;
                end
                if (go[k]) go_len++;
                if (go_prev && st_prev == 2'd3 && go[k]) bad++;
                done_cnt += int'(done[k]);
                if (mid_start && busy_cyc == 3) start[k] = 1'b1;
                if (mid_start && busy_cyc == 5) start[k] = 1'b0;
            end
            go_prev = go[k]; st_prev = st[k]; add_prev = add[k];
        end
        start[k] = 1'b0; abort[k] = 1'b0; stuck[k] = 1'b0; pre_busy[k] = 1'b0;
        chk("run_started", started, 1);
        chk("run_ended", ended, 1);
        chk("done_count", done_cnt, exp_done);
        chk("err_flag", err[k], stk);
        chk("handshake_rules", bad, 0);
        chk("final_add", add[k], exp_q[n_exp-1]);
        if (dyn) begin
            chk("go_pulses", got_q.size(), n_exp);
            chk("go_addr_seq", mism(got_q, exp_q, n_exp), 0);
        end else begin
            chk("go_static", got_q.size(), 0);
            chk("add_seq_len", seen_q.size(), n_exp);
            chk("add_seq", mism(seen_q, exp_q, n_exp), 0);
            chk("busy_len", busy_cyc, n_exp * (P_DWELL[k] + 1));
        end
        if (stk) chk("timeout_go_len", go_len, P_TMO[k]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle_busy += int'(busy[k]) + int'(done[k]);
        end
        chk("stays_idle", idle_busy, 0);
    endtask

    initial begin
        bit hit;
        int k, ai;
        logic [2:0] m;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_add", add[i], 0);   chk("rst_func", func[i], 0);
            chk("rst_go", go[i], 0);     chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0); chk("rst_err", err[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_run(0, 3'd3, -1, 0, 0, 0);   // dynamic 2,3,4
        do_run(0, 3'd0, -1, 0, 0, 0);   // static with dwell
        do_run(0, 3'd5, -1, 1, 0, 0);   // St stuck at idle -> timeout
        do_run(0, 3'd6, -1, 0, 0, 0);   // next START clears ERR
        do_run(1, 3'd1, -1, 0, 0, 0);   // wrap 14,15,0,1
        do_run(1, 3'd4, -1, 0, 0, 0);
        do_run(0, 3'd3, 1, 0, 0, 0);    // abort during 2nd ISSUE
        do_run(0, 3'd7, -1, 0, 0, 1);   // controller busy at ISSUE entry
        do_run(0, 3'd4, -1, 0, 1, 0);   // START while BUSY ignored

        // Reset in the middle of a handshake.
        mode[0] = 3'd3;
        @(negedge clk);
        start[0] = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 3) start[0] = 1'b0;
            if (go[0] && st[0] == 2'd2) begin hit = 1'b1; break; end
        end
        start[0] = 1'b0;
        chk("rst_mid_reached", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_add", add[0], 0);   chk("rst_mid_func", func[0], 0);
        chk("rst_mid_go", go[0], 0);     chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_done", done[0], 0); chk("rst_mid_err", err[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_idle", busy[0], 0);

        for (int r = 0; r < 14; r++) begin
            k  = $urandom_range(0, 1);
            m  = 3'($urandom_range(0, 7));
            ai = (m >= 3'd3 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            do_run(k, m, ai, 0, (ai < 0) ? bit'($urandom_range(0, 1)) : 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
